decision_scorer: RTL and testbench
==================================

DECISION_SCORER -- requirements
Module: decision_scorer

Interface
REQ-001 Parameter NUM_VARS, default 16: number of variables, indexed 1..NUM_VARS; index 0 means "none".
REQ-002 Parameter SCORE_W, default 8: width of each per-variable activity score.
REQ-003 Parameter LANES, default 4: variables examined per scan cycle; NUM_VARS need not be a multiple of LANES.
REQ-004 Derived VW = $clog2(NUM_VARS+1): width of every variable index port.
REQ-005 Ports, one per line: name  direction  width  meaning.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- assigned  in  [NUM_VARS:1]  1 = variable currently assigned.
- bump_valid  in  1  increment score of bump_var this cycle.
- bump_var  in  VW  variable to bump.
- decay  in  1  halve all scores this cycle.
- req  in  1  start a decision scan (pulse or level).
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse: result is valid.
- valid  out  1  a free variable was found; held until the next done.
- next_var  out  VW  chosen variable; 0 when valid=0; held until the next done.
- next_phase  out  1  suggested polarity for next_var.
- phase_valid  in  1  record a polarity.
- phase_var  in  VW  variable whose polarity is recorded.
- phase_val  in  1  polarity value.

Function
REQ-006 Score storage: one SCORE_W-bit register per variable.
REQ-007 Bump: score[bump_var] increments by 1, saturating at 2^SCORE_W-1.
REQ-008 Bump with bump_var = 0 or bump_var > NUM_VARS: ignored.
REQ-009 Decay: every score becomes score>>1 in that cycle.
REQ-010 Bump and decay in the same cycle: the bumped variable's new score is (score>>1)+1, saturating.
REQ-011 FSM states IDLE, SCAN, DONE. Transitions:
- IDLE -> SCAN on req: clears the best candidate and sets the lane cursor to 1.
- SCAN: each cycle examines variables cursor..cursor+LANES-1 (those <= NUM_VARS), then advances the cursor by LANES.
- SCAN -> DONE after ceil(NUM_VARS/LANES) cycles.
- DONE -> IDLE unconditionally.
REQ-012 Examination, using values present in the examine cycle:
- A candidate is a variable with assigned = 0.
- Best = highest score; ties go to the lowest index, within a lane group and across groups.
REQ-013 busy = 1 in SCAN and DONE.
REQ-014 done = 1 only in DONE; next_var, valid and next_phase update in that same cycle.
REQ-015 Latency: req sampled in IDLE at edge N gives done high in the cycle after edge N+ceil(NUM_VARS/LANES)+1 (5-cycle scan-to-done for the defaults).
REQ-016 req is ignored while busy = 1; req held high in the DONE cycle is not sampled, so req is re-sampled first in IDLE.
REQ-017 No candidate found: valid = 0 and next_var = 0.
REQ-018 Bumps and decays are accepted in every state; a change to an already-examined variable does not alter the scan in progress.
REQ-019 Outputs are registered; no combinational path from any input to any output.

Reset
REQ-020 rst asynchronously forces:
- FSM to IDLE;
- all scores and all saved phases to 0;
- busy, done, valid, next_phase to 0 and next_var to 0.
REQ-021 rst asserted mid-scan aborts the scan; no done is produced for that request.

Configuration
REQ-022 Macro DECISION_SCORER_PHASE_SAVING_EN, when defined:
- a per-variable phase bit is written on phase_valid (index 0 and indices > NUM_VARS are ignored);
- next_phase = saved phase of next_var, sampled at DONE.
REQ-023 Without the macro: no phase storage is built, phase_* inputs are ignored, and next_phase is constant 0.

Verification
REQ-024 Defaults; reset; assigned = 0; req -> done after 5 cycles with next_var = 1, valid = 1 (all-zero scores, lowest-index tie-break).
REQ-025 Bump var 9 three times and var 3 twice; assigned = 0; req -> next_var = 9. Then set assigned[9] = 1; req -> next_var = 3.
REQ-026 Bump var 5 300 times with SCORE_W = 8 -> score saturates at 255; one decay -> 127; decay together with a bump of var 5 -> 64.
REQ-027 assigned = all ones; req -> done with valid = 0 and next_var = 0. Then NUM_VARS = 10, LANES = 4, assigned = 0x3FF except var 10 free -> next_var = 10 after a 3-cycle scan.
REQ-028 Assert rst during the second SCAN cycle -> busy = 0 immediately, no done pulse, and all scores read 0 (next req returns var 1). Also: req pulsed while busy -> exactly one done.
REQ-029 With DECISION_SCORER_PHASE_SAVING_EN: phase_var = 4, phase_val = 1; make var 4 the winner -> next_phase = 1. Without the macro -> next_phase = 0.

Source files
------------

// File: rtl/decision_scorer.sv
// decision_scorer: activity-score branching heuristic. Scans LANES variables per
// cycle and picks the unassigned variable with the highest score. Ties go to the
// lowest index.
// Optional feature: define DECISION_SCORER_PHASE_SAVING_EN to store a per-variable
// saved polarity, which is reported on next_phase.
module decision_scorer #(
  parameter int unsigned NUM_VARS = 16,
  parameter int unsigned SCORE_W  = 8,
  parameter int unsigned LANES    = 4,
  localparam int unsigned VW      = $clog2(NUM_VARS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_VARS:1] assigned,
  input  logic              bump_valid,
  input  logic [VW-1:0]     bump_var,
  input  logic              decay,
  input  logic              req,
  output logic              busy,
  output logic              done,
  output logic              valid,
  output logic [VW-1:0]     next_var,
  output logic              next_phase,
  input  logic              phase_valid,
  input  logic [VW-1:0]     phase_var,
  input  logic              phase_val
);

  // The cursor must be able to hold the first index past the last lane group.
  localparam int unsigned CW = $clog2(NUM_VARS + LANES + 1);
  localparam logic [SCORE_W-1:0] SMAX = {SCORE_W{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t               r_state;
  logic [SCORE_W-1:0]   r_score [1:NUM_VARS];
  logic [SCORE_W-1:0]   w_score_nxt [1:NUM_VARS];
  logic [CW-1:0]        r_cursor;

  // Running best over the groups that have already been merged.
  logic                 r_best_vld;
  logic [VW-1:0]        r_best_idx;
  logic [SCORE_W-1:0]   r_best_score;

  // Winner of the most recently examined group. It is merged on the following cycle.
  logic                 r_grp_vld;
  logic [VW-1:0]        r_grp_idx;
  logic [SCORE_W-1:0]   r_grp_score;

  logic                 w_lane_vld;
  logic [VW-1:0]        w_lane_idx;
  logic [SCORE_W-1:0]   w_lane_score;

  logic                 w_mrg_vld;
  logic [VW-1:0]        w_mrg_idx;
  logic [SCORE_W-1:0]   w_mrg_score;
  logic                 w_mrg_phase;

  // Next score per variable: optional halving, then a saturating bump.
  always_comb begin
    for (int v = 1; v <= int'(NUM_VARS); v++) begin
      w_score_nxt[v] = decay ? (r_score[v] >> 1) : r_score[v];
      if (bump_valid && (bump_var == VW'(v)) && (w_score_nxt[v] != SMAX)) begin
        w_score_nxt[v] = w_score_nxt[v] + SCORE_W'(1);
      end
    end
  end

  // Score bank. Bumps and decays are accepted in every FSM state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 1; v <= int'(NUM_VARS); v++) r_score[v] <= '0;
    end else begin
      for (int v = 1; v <= int'(NUM_VARS); v++) r_score[v] <= w_score_nxt[v];
    end
  end

  // Best free variable inside the current lane window. Ascending order with a strict > keeps the lowest index on ties.
  always_comb begin
    w_lane_vld   = 1'b0;
    w_lane_idx   = '0;
    w_lane_score = '0;
    for (int v = 1; v <= int'(NUM_VARS); v++) begin
      if ((v >= int'(r_cursor)) && (v < int'(r_cursor) + int'(LANES)) && !assigned[v] &&
          (!w_lane_vld || (r_score[v] > w_lane_score))) begin
        w_lane_vld   = 1'b1;
        w_lane_idx   = VW'(v);
        w_lane_score = r_score[v];
      end
    end
  end

  // Merge the group winner into the running best. The group always has higher indices, so it only wins on a strictly higher score.
  always_comb begin
    w_mrg_vld   = r_best_vld;
    w_mrg_idx   = r_best_idx;
    w_mrg_score = r_best_score;
    if (r_grp_vld && (!r_best_vld || (r_grp_score > r_best_score))) begin
      w_mrg_vld   = 1'b1;
      w_mrg_idx   = r_grp_idx;
      w_mrg_score = r_grp_score;
    end
  end

`ifdef DECISION_SCORER_PHASE_SAVING_EN
  logic r_phase [1:NUM_VARS];

  // Saved polarity per variable. Index 0 and out-of-range indices never match.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 1; v <= int'(NUM_VARS); v++) r_phase[v] <= 1'b0;
    end else begin
      for (int v = 1; v <= int'(NUM_VARS); v++) begin
        if (phase_valid && (phase_var == VW'(v))) r_phase[v] <= phase_val;
      end
    end
  end

  // Saved polarity of the variable that is about to be reported.
  always_comb begin
    w_mrg_phase = 1'b0;
    for (int v = 1; v <= int'(NUM_VARS); v++) begin
      if (w_mrg_vld && (w_mrg_idx == VW'(v))) w_mrg_phase = r_phase[v];
    end
  end
`else
  logic w_unused;
  assign w_unused    = ^{phase_valid, phase_var, phase_val, w_mrg_score};
  assign w_mrg_phase = 1'b0;
`endif

  // Scan FSM with registered outputs. The final SCAN cycle drains the last group winner into the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cursor     <= '0;
      r_best_vld   <= 1'b0;
      r_best_idx   <= '0;
      r_best_score <= '0;
      r_grp_vld    <= 1'b0;
      r_grp_idx    <= '0;
      r_grp_score  <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      valid        <= 1'b0;
      next_var     <= '0;
      next_phase   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_state      <= S_SCAN;
            busy         <= 1'b1;
            r_cursor     <= CW'(1);
            r_best_vld   <= 1'b0;
            r_best_idx   <= '0;
            r_best_score <= '0;
            r_grp_vld    <= 1'b0;
            r_grp_idx    <= '0;
            r_grp_score  <= '0;
          end
        end
        S_SCAN: begin
          if (int'(r_cursor) <= int'(NUM_VARS)) begin
            r_best_vld   <= w_mrg_vld;
            r_best_idx   <= w_mrg_idx;
            r_best_score <= w_mrg_score;
            r_grp_vld    <= w_lane_vld;
            r_grp_idx    <= w_lane_idx;
            r_grp_score  <= w_lane_score;
            r_cursor     <= r_cursor + CW'(LANES);
          end else begin
            r_state    <= S_DONE;
            done       <= 1'b1;
            valid      <= w_mrg_vld;
            next_var   <= w_mrg_vld ? w_mrg_idx : '0;
            next_phase <= w_mrg_phase;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decision_scorer.sv
// Testbench for decision_scorer: table-driven scans plus a scoreboard of expected results.
module tb_decision_scorer;

`ifdef DECISION_SCORER_PHASE_SAVING_EN
  localparam logic PH = 1'b1;
`else
  localparam logic PH = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [16:1] assigned;
  logic        bump_valid;
  logic [4:0]  bump_var;
  logic        decay;
  logic        req;
  logic        busy;
  logic        done;
  logic        valid;
  logic [4:0]  next_var;
  logic        next_phase;
  logic        phase_valid;
  logic [4:0]  phase_var;
  logic        phase_val;

  // Second instance with NUM_VARS that is not a multiple of LANES.
  logic [10:1] a10;
  logic        req10;
  logic        zero1;
  logic [3:0]  zero4;
  logic        busy10;
  logic        done10;
  logic        valid10;
  logic [3:0]  nv10;
  logic        np10;

  decision_scorer dut (
    .clk(clk), .rst(rst), .assigned(assigned), .bump_valid(bump_valid), .bump_var(bump_var),
    .decay(decay), .req(req), .busy(busy), .done(done), .valid(valid), .next_var(next_var),
    .next_phase(next_phase), .phase_valid(phase_valid), .phase_var(phase_var), .phase_val(phase_val)
  );

  decision_scorer #(.NUM_VARS(10), .SCORE_W(8), .LANES(4)) dut10 (
    .clk(clk), .rst(rst), .assigned(a10), .bump_valid(zero1), .bump_var(zero4),
    .decay(zero1), .req(req10), .busy(busy10), .done(done10), .valid(valid10), .next_var(nv10),
    .next_phase(np10), .phase_valid(zero1), .phase_var(zero4), .phase_val(zero1)
  );

  typedef struct {
    logic [16:1] asg;
    logic [4:0]  v;
    logic        vld;
  } vec_t;

  typedef struct {
    logic [4:0] v;
    logic       vld;
    logic       ph;
  } exp_t;

  exp_t sbq[$];
  vec_t tbl [8];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_done   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Scoreboard: every done pulse is compared against the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      n_done++;
      n_checks++;
      if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: next_var=%0d valid=%0d with no pending request", next_var, valid);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        if ({next_var, valid, next_phase} !== {e.v, e.vld, e.ph}) begin
          n_fail++;
          $display("FAIL result: got var=%0d valid=%0d phase=%0d expected var=%0d valid=%0d phase=%0d",
                   next_var, valid, next_phase, e.v, e.vld, e.ph);
        end
      end
    end
  end

  task automatic bump(input logic [4:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      bump_valid = 1'b1;
      bump_var   = v;
      @(posedge clk); #1;
    end
    bump_valid = 1'b0;
  endtask

  task automatic decay_op(input logic bv, input logic [4:0] v);
    decay      = 1'b1;
    bump_valid = bv;
    bump_var   = v;
    @(posedge clk); #1;
    decay      = 1'b0;
    bump_valid = 1'b0;
  endtask

  task automatic pwrite(input logic [4:0] v, input logic val);
    phase_valid = 1'b1;
    phase_var   = v;
    phase_val   = val;
    @(posedge clk); #1;
    phase_valid = 1'b0;
  endtask

  // One request on the default instance, with a 5-cycle latency to done.
  task automatic scan(input logic [16:1] a, input logic [4:0] ev, input logic evld,
                      input logic eph, input string nm);
    exp_t e;
    int   k;
    assigned = a;
    e.v = ev; e.vld = evld; e.ph = eph;
    sbq.push_back(e);
    req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    chk({nm, "_busy"}, 32'(busy), 32'd1);
    k = 0;
    while (!done && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk({nm, "_latency"}, 32'(k), 32'd5);
    @(posedge clk); #1;
    chk({nm, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int k;
    int n0;
    rst = 1'b1; assigned = '0; bump_valid = 1'b0; bump_var = '0; decay = 1'b0; req = 1'b0;
    phase_valid = 1'b0; phase_var = '0; phase_val = 1'b0;
    a10 = '0; req10 = 1'b0; zero1 = 1'b0; zero4 = '0;

    // Scores after the bumps below: v3=2, v9=3, v14=3, all others 0.
    tbl[0] = '{16'h0000, 5'd9,  1'b1};
    tbl[1] = '{16'h0100, 5'd14, 1'b1};
    tbl[2] = '{16'h2100, 5'd3,  1'b1};
    tbl[3] = '{16'h2104, 5'd1,  1'b1};
    tbl[4] = '{16'h7FFF, 5'd16, 1'b1};
    tbl[5] = '{16'hFFFF, 5'd0,  1'b0};
    tbl[6] = '{16'hDFFF, 5'd14, 1'b1};
    tbl[7] = '{16'hFEFF, 5'd9,  1'b1};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",  32'(busy),       32'd0);
    chk("rst_done",  32'(done),       32'd0);
    chk("rst_valid", 32'(valid),      32'd0);
    chk("rst_var",   32'(next_var),   32'd0);
    chk("rst_phase", 32'(next_phase), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    scan(16'h0000, 5'd1, 1'b1, 1'b0, "all_zero");

    bump(5'd9, 3);
    bump(5'd3, 2);
    bump(5'd14, 3);
    bump(5'd0, 2);
    bump(5'd20, 2);
    for (int i = 0; i < 8; i++) begin
      scan(tbl[i].asg, tbl[i].v, tbl[i].vld, 1'b0, $sformatf("vec%0d", i));
    end

    pwrite(5'd4, 1'b1);
    pwrite(5'd0, 1'b1);
    pwrite(5'd20, 1'b1);
    scan(16'hFFF7, 5'd4, 1'b1, PH, "phase_v4");
    scan(16'hFFEF, 5'd5, 1'b1, 1'b0, "phase_v5");

    // Saturation and decay, observed by racing var5 against var6.
    bump(5'd5, 300);
    bump(5'd6, 255);
    scan(16'hFFCF, 5'd5, 1'b1, 1'b0, "sat_tie");
    decay_op(1'b0, 5'd0);
    scan(16'hFFCF, 5'd5, 1'b1, 1'b0, "decay_tie");
    bump(5'd6, 1);
    scan(16'hFFCF, 5'd6, 1'b1, 1'b0, "decay_lt128");
    decay_op(1'b1, 5'd5);
    scan(16'hFFCF, 5'd5, 1'b1, 1'b0, "decay_bump_tie64");
    bump(5'd6, 1);
    scan(16'hFFCF, 5'd6, 1'b1, 1'b0, "decay_bump_lt65");

    // Reset during the second scan cycle aborts the request.
    n0 = n_done;
    assigned = 16'h0000;
    req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(n_done - n0), 32'd0);
    scan(16'h0000, 5'd1, 1'b1, 1'b0, "post_rst");
    scan(16'hFFF7, 5'd4, 1'b1, 1'b0, "post_rst_phase");

    // req held high through the whole scan and the DONE cycle must give exactly one result.
    n0 = n_done;
    begin
      exp_t e;
      e.v = 5'd1; e.vld = 1'b1; e.ph = 1'b0;
      sbq.push_back(e);
    end
    assigned = 16'h0000;
    req = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    req = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("busy_req_once", 32'(n_done - n0), 32'd1);

    // NUM_VARS=10: only var10 is free, and the scan takes 3 groups.
    a10 = 10'h1FF;
    req10 = 1'b1;
    @(posedge clk); #1;
    req10 = 1'b0;
    k = 0;
    while (!done10 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("n10_latency", 32'(k), 32'd4);
    chk("n10_var",     32'(nv10), 32'd10);
    chk("n10_valid",   32'(valid10), 32'd1);
    @(posedge clk); #1;
    chk("n10_idle",    32'(busy10), 32'd0);

    chk("sbq_drained", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
